// File: rtl/bram_log_ctrl_pkg.sv
// Shared types and constants for the sample-logging BRAM capture/playback controller.
package bram_log_ctrl_pkg;

  localparam int NB_ADDR_DEFAULT = 15;
  localparam int NB_DATA_DEFAULT = 14;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    DONE     = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_HOLD  = 3'd5
  } state_t;

  // Highest buffer address for a given address width (all-ones pointer value).
  function automatic int unsigned last_addr(input int unsigned nb_addr);
    return (32'd1 << nb_addr) - 32'd1;
  endfunction

endpackage

// File: rtl/bram_log_ctrl.sv
// Fills the logging BRAM with one full buffer on i_run_log, then plays it out
// word by word over valid/ready on i_read_log. Owns both BRAM ports.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no valid buffer; waiting for i_run_log
// CAPTURE  | writing i_data at wr_ptr on each i_valid cycle
// DONE     | buffer full; waiting for i_run_log or i_read_log
// RD_ISSUE | read strobe for rd_ptr
// RD_WAIT  | BRAM read data arriving; latched into o_data
// RD_HOLD  | o_data/o_data_valid held until i_data_ready
module bram_log_ctrl
  import bram_log_ctrl_pkg::*;
#(
  parameter int NB_ADDR = NB_ADDR_DEFAULT,
  parameter int NB_DATA = NB_DATA_DEFAULT
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_run_log,
  input  logic               i_read_log,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_full,
  output logic               o_busy,
  output logic [NB_DATA-1:0] o_bram_data,
  output logic [NB_ADDR-1:0] o_bram_write_addr,
  output logic               o_bram_write_enable,
  output logic [NB_ADDR-1:0] o_bram_read_addr,
  output logic               o_bram_read_enable,
  input  logic [NB_DATA-1:0] i_bram_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_data_valid,
  input  logic               i_data_ready
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(last_addr(NB_ADDR));

  state_t             state;
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] rd_ptr;

  // Write port is combinational so a sample is stored in the cycle it is valid.
  assign o_bram_write_enable = (state == CAPTURE) && i_valid;
  assign o_bram_write_addr   = wr_ptr;
  assign o_bram_data         = i_data;
  assign o_bram_read_enable  = (state == RD_ISSUE);
  assign o_bram_read_addr    = rd_ptr;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_full       <= 1'b0;
      o_busy       <= 1'b0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_run_log) begin
            state  <= CAPTURE;
            wr_ptr <= '0;
            o_busy <= 1'b1;
          end
        end

        CAPTURE: begin
          if (i_valid) begin
            if (wr_ptr == LAST_ADDR) begin
              state  <= DONE;
              wr_ptr <= '0;
              o_full <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end

        DONE: begin
          // A new capture takes priority over replaying the old one.
          if (i_run_log) begin
            state  <= CAPTURE;
            wr_ptr <= '0;
            o_full <= 1'b0;
            o_busy <= 1'b1;
          end else if (i_read_log) begin
            state  <= RD_ISSUE;
            rd_ptr <= '0;
            o_busy <= 1'b1;
          end
        end

        RD_ISSUE: begin
          state <= RD_WAIT;
        end

        RD_WAIT: begin
          o_data       <= i_bram_data;
          o_data_valid <= 1'b1;
          state        <= RD_HOLD;
        end

        RD_HOLD: begin
          if (i_data_ready) begin
            o_data_valid <= 1'b0;
            if (rd_ptr == LAST_ADDR) begin
              state  <= DONE;
              rd_ptr <= '0;
              o_busy <= 1'b0;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
              state  <= RD_ISSUE;
            end
          end
        end

        default: begin
          state        <= IDLE;
          o_full       <= 1'b0;
          o_busy       <= 1'b0;
          o_data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_log_ctrl.sv
// Directed bench for bram_log_ctrl with a 16-word registered-read BRAM model attached.
module tb_bram_log_ctrl;

  localparam int NB_ADDR = 4;
  localparam int NB_DATA = 14;

  logic               clock = 1'b0;
  logic               i_reset;
  logic               i_run_log;
  logic               i_read_log;
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               o_full;
  logic               o_busy;
  logic [NB_DATA-1:0] o_bram_data;
  logic [NB_ADDR-1:0] o_bram_write_addr;
  logic               o_bram_write_enable;
  logic [NB_ADDR-1:0] o_bram_read_addr;
  logic               o_bram_read_enable;
  logic [NB_DATA-1:0] i_bram_data;
  logic [NB_DATA-1:0] o_data;
  logic               o_data_valid;
  logic               i_data_ready;

  int total  = 0;
  int passed = 0;

  logic [NB_DATA-1:0] mem [16];
  int wr_count = 0;
  int rd_count = 0;

  always #5 clock = ~clock;

  bram_log_ctrl #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) dut (
    .clock              (clock),
    .i_reset            (i_reset),
    .i_run_log          (i_run_log),
    .i_read_log         (i_read_log),
    .i_data             (i_data),
    .i_valid            (i_valid),
    .o_full             (o_full),
    .o_busy             (o_busy),
    .o_bram_data        (o_bram_data),
    .o_bram_write_addr  (o_bram_write_addr),
    .o_bram_write_enable(o_bram_write_enable),
    .o_bram_read_addr   (o_bram_read_addr),
    .o_bram_read_enable (o_bram_read_enable),
    .i_bram_data        (i_bram_data),
    .o_data             (o_data),
    .o_data_valid       (o_data_valid),
    .i_data_ready       (i_data_ready)
  );

  // BRAM model: write-first not needed, registered read with 1-cycle latency.
  always @(posedge clock) begin
    if (o_bram_write_enable) begin
      mem[o_bram_write_addr] <= o_bram_data;
      wr_count <= wr_count + 1;
    end
    if (o_bram_read_enable) begin
      i_bram_data <= mem[o_bram_read_addr];
      rd_count <= rd_count + 1;
    end
  end

  typedef struct {
    logic               run;
    logic               read;
    logic               valid;
    logic               ready;
    logic [NB_DATA-1:0] data;
    logic               exp_we;
    logic               exp_re;
    logic [NB_ADDR-1:0] exp_wa;
    logic               exp_full;
    logic               exp_busy;
    logic               exp_dv;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    i_run_log    = 1'b0;
    i_read_log   = 1'b0;
    i_valid      = 1'b0;
    i_data       = '0;
    i_data_ready = 1'b0;
  endtask

  task automatic capture_full(input logic [NB_DATA-1:0] base);
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0;
    i_valid   = 1'b1;
    for (int n = 0; n < 16; n++) begin
      i_data = base + NB_DATA'(n);
      tick();
    end
    i_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wr0, rd0, lat, gap, stable;

    //        run   read  valid ready data      we    re    wa    full  busy  dv
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 14'h000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 14'h000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 14'h3FF, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 14'h3FF, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 14'h100, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h000, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 14'h000, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 14'h101, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0};

    clear_inputs();
    i_reset = 1'b1;
    #1;
    check("reset_full",  32'(o_full), 32'd0);
    check("reset_busy",  32'(o_busy), 32'd0);
    check("reset_dv",    32'(o_data_valid), 32'd0);
    check("reset_odata", 32'(o_data), 32'd0);
    check("reset_we",    32'(o_bram_write_enable), 32'd0);
    check("reset_re",    32'(o_bram_read_enable), 32'd0);
    repeat (2) tick();
    i_reset = 1'b0;
    tick();

    // Idle behaviour, command cycle, and ignored commands during capture.
    for (int v = 0; v < 8; v++) begin
      i_run_log    = vecs[v].run;
      i_read_log   = vecs[v].read;
      i_valid      = vecs[v].valid;
      i_data_ready = vecs[v].ready;
      i_data       = vecs[v].data;
      #1;
      if (o_bram_write_enable !== vecs[v].exp_we)
        $display("vec %0d", v);
      check("vec_we",   32'(o_bram_write_enable), 32'(vecs[v].exp_we));
      check("vec_re",   32'(o_bram_read_enable),  32'(vecs[v].exp_re));
      check("vec_wa",   32'(o_bram_write_addr),   32'(vecs[v].exp_wa));
      tick();
      check("vec_full", 32'(o_full),       32'(vecs[v].exp_full));
      check("vec_busy", 32'(o_busy),       32'(vecs[v].exp_busy));
      check("vec_dv",   32'(o_data_valid), 32'(vecs[v].exp_dv));
    end
    clear_inputs();

    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tick();

    // Full capture with i_valid held high: exactly 16 cycles.
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0;
    wr0 = wr_count;
    i_valid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      i_data = 14'h100 + NB_DATA'(n);
      tick();
      if (n == 14) check("cap_full_early", 32'(o_full), 32'd0);
    end
    i_valid = 1'b0;
    check("cap_full",   32'(o_full), 32'd1);
    check("cap_busy",   32'(o_busy), 32'd0);
    check("cap_writes", 32'(wr_count - wr0), 32'd16);
    for (int a = 0; a < 16; a++)
      check("cap_mem", 32'(mem[a]), 32'h100 + 32'(a));
    tick();
    check("done_no_write", 32'(wr_count - wr0), 32'd16);

    // Capture with i_valid toggling; junk on invalid cycles must not be written.
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0;
    check("recap_full_clr", 32'(o_full), 32'd0);
    check("recap_busy",     32'(o_busy), 32'd1);
    wr0 = wr_count;
    for (int c = 0; c < 32; c++) begin
      i_valid = ((c % 2) == 0);
      i_data  = i_valid ? (14'h100 + NB_DATA'(c / 2)) : 14'h3FFF;
      tick();
      if (c == 29) check("tog_full_early", 32'(o_full), 32'd0);
    end
    i_valid = 1'b0;
    check("tog_writes", 32'(wr_count - wr0), 32'd16);
    check("tog_full",   32'(o_full), 32'd1);
    check("tog_busy",   32'(o_busy), 32'd0);

    // Playback with ready held high, stalling on word 5.
    i_data_ready = 1'b1;
    rd0 = rd_count;
    i_read_log = 1'b1;
    tick();
    i_read_log = 1'b0;
    check("pb_busy", 32'(o_busy), 32'd1);
    lat = 1;
    while (!o_data_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("pb_latency", 32'(lat), 32'd3);
    for (int w = 0; w < 16; w++) begin
      if (w > 0) begin
        gap = 0;
        while (!o_data_valid && gap < 10) begin
          tick();
          gap++;
        end
        check("pb_period", 32'(gap + 1), 32'd3);
      end
      check("pb_data", 32'(o_data), 32'h100 + 32'(w));
      if (w == 5) begin
        i_data_ready = 1'b0;
        wr0 = rd_count;
        stable = 1;
        repeat (10) begin
          tick();
          if (!(o_data_valid === 1'b1 && o_data === 14'h105)) stable = 0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_reads",  32'(rd_count - wr0), 32'd0);
        i_data_ready = 1'b1;
      end
      tick();
    end
    check("pb_end_full",  32'(o_full), 32'd1);
    check("pb_end_busy",  32'(o_busy), 32'd0);
    check("pb_end_dv",    32'(o_data_valid), 32'd0);
    check("pb_reads",     32'(rd_count - rd0), 32'd16);
    i_data_ready = 1'b0;

    // Reset after 7 writes of a new capture.
    i_run_log = 1'b1;
    tick();
    i_run_log = 1'b0;
    wr0 = wr_count;
    i_valid = 1'b1;
    i_data  = 14'h2AA;
    repeat (7) tick();
    check("mid_writes", 32'(wr_count - wr0), 32'd7);
    i_reset = 1'b1;
    #1;
    check("rst_async_busy", 32'(o_busy), 32'd0);
    check("rst_async_we",   32'(o_bram_write_enable), 32'd0);
    tick();
    check("rst_full", 32'(o_full), 32'd0);
    i_reset = 1'b0;
    i_valid = 1'b0;
    tick();

    // Read command in IDLE after reset is ignored.
    rd0 = rd_count;
    i_read_log = 1'b1;
    i_data_ready = 1'b1;
    tick();
    i_read_log = 1'b0;
    stable = 1;
    repeat (5) begin
      tick();
      if (o_data_valid !== 1'b0 || o_busy !== 1'b0) stable = 0;
    end
    check("idle_read_ignored", 32'(stable), 32'd1);
    check("idle_no_reads",     32'(rd_count - rd0), 32'd0);
    i_data_ready = 1'b0;

    // Both commands in DONE: capture wins.
    capture_full(14'h100);
    check("cap2_full", 32'(o_full), 32'd1);
    i_run_log  = 1'b1;
    i_read_log = 1'b1;
    tick();
    i_run_log  = 1'b0;
    i_read_log = 1'b0;
    check("both_full", 32'(o_full), 32'd0);
    check("both_busy", 32'(o_busy), 32'd1);
    i_valid = 1'b1;
    i_data  = 14'h055;
    #1;
    check("both_we", 32'(o_bram_write_enable), 32'd1);
    check("both_re", 32'(o_bram_read_enable),  32'd0);
    tick();
    i_valid = 1'b0;
    check("both_dv", 32'(o_data_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
